// File: rtl/return_stack_pkg.sv
// Shared decode constants and per-thread state type for the return-stack front end.
package return_stack_pkg;

  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [4:0] RA_REG     = 5'd31;

  localparam int NUM_THREADS = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } thr_state_e;

endpackage

// File: rtl/return_stack_ctrl_fifo.sv
// Per-thread check queue of outstanding return-target predictions; flush wins over push.
module ret_check_fifo #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int CHECK_DEPTH   = 4,
  parameter int CNT_W         = $clog2(CHECK_DEPTH + 1)
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     push_i,
  input  logic [ADDRESS_WIDTH-1:0] data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [CNT_W-1:0]         count_o,
  output logic [ADDRESS_WIDTH-1:0] head_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(CHECK_DEPTH);

  logic [ADDRESS_WIDTH-1:0] mem_q [CHECK_DEPTH];
  logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PTR_W'(1);
      if (pop_i)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_Clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/return_stack_ctrl.sv
// Decodes jal/jalr/jr $31 into jump-stack commands and verifies popped predictions at resolve.
module return_stack_ctrl
  import return_stack_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 22,
  parameter int CHECK_DEPTH   = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_instr,
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  input  logic [1:0]               i_thread,
  output logic                     o_push,
  output logic                     o_pop,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [1:0]               o_thread,
  input  logic [ADDRESS_WIDTH-1:0] i_stack_address,
  output logic                     o_pred_valid,
  output logic [ADDRESS_WIDTH-1:0] o_pred_target,
  input  logic                     i_resolve_valid,
  input  logic [1:0]               i_resolve_thread,
  input  logic [ADDRESS_WIDTH-1:0] i_resolve_target,
  output logic                     o_redirect,
  output logic [1:0]               o_redirect_thread,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_target,
  output logic                     o_error
);

  localparam int CNT_W = $clog2(CHECK_DEPTH + 1);

  logic [5:0] opcode, funct;
  logic [4:0] rs;
  logic       dec_push, dec_pop;

  assign opcode   = i_instr[31:26];
  assign rs       = i_instr[25:21];
  assign funct    = i_instr[5:0];
  assign dec_push = (opcode == OP_JAL) || ((opcode == OP_SPECIAL) && (funct == FN_JALR));
  assign dec_pop  = (opcode == OP_SPECIAL) && (funct == FN_JR) && (rs == RA_REG);

  logic [NUM_THREADS-1:0]   q_push, q_pop, q_flush, q_empty;
  logic [CNT_W-1:0]         q_cnt  [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] q_head [NUM_THREADS];

  logic                     stage_push_q, stage_push_d, stage_pop_q, stage_pop_d;
  logic [ADDRESS_WIDTH-1:0] stage_addr_q, stage_addr_d;
  logic [1:0]               stage_thread_q, stage_thread_d;

  logic                     redirect_q, redirect_d, error_q, error_d;
  logic [1:0]               redir_thread_q, redir_thread_d;
  logic [ADDRESS_WIDTH-1:0] redir_target_q, redir_target_d;

  thr_state_e state_q [NUM_THREADS];
  thr_state_e state_d [NUM_THREADS];

  logic             res_hit, mismatch, pend_pop, pop_room, accept;
  logic [CNT_W:0]   occupancy;

  assign res_hit  = i_resolve_valid && !q_empty[i_resolve_thread];
  assign mismatch = res_hit && (q_head[i_resolve_thread] != i_resolve_target);

  // A pop sitting in the stage has not reached its queue yet but already owns a slot.
  assign pend_pop  = stage_pop_q && (stage_thread_q == i_thread);
  assign occupancy = {1'b0, q_cnt[i_thread]} + (CNT_W + 1)'(pend_pop);
  assign pop_room  = occupancy < (CNT_W + 1)'(CHECK_DEPTH);

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
    assign q_push[g]  = stage_pop_q && (stage_thread_q == 2'(g));
    assign q_pop[g]   = res_hit && (i_resolve_thread == 2'(g));
    assign q_flush[g] = mismatch && (i_resolve_thread == 2'(g));

    ret_check_fifo #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .CHECK_DEPTH  (CHECK_DEPTH),
      .CNT_W        (CNT_W)
    ) u_fifo (
      .i_Clk    (i_Clk),
      .i_Reset_n(i_Reset_n),
      .push_i   (q_push[g]),
      .data_i   (i_stack_address),
      .pop_i    (q_pop[g]),
      .flush_i  (q_flush[g]),
      .count_o  (q_cnt[g]),
      .head_o   (q_head[g]),
      .empty_o  (q_empty[g])
    );
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_THREADS; i++) state_q[i] <= RUN;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        RUN:     if (q_flush[i]) state_d[i] = FLUSH;
        FLUSH:   state_d[i] = RUN;
        default: state_d[i] = RUN;
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q[i_thread] == RUN) && (!dec_pop || pop_room);
  end

  // A decode for the thread being redirected this cycle is on the wrong path.
  assign accept = i_valid && o_ready && !(mismatch && (i_resolve_thread == i_thread));

  always_comb begin
    stage_push_d   = accept && dec_push;
    stage_pop_d    = accept && dec_pop;
    stage_addr_d   = (accept && dec_push) ? i_pc + ADDRESS_WIDTH'(2) : '0;
    stage_thread_d = (accept && (dec_push || dec_pop)) ? i_thread : 2'd0;
    redirect_d     = mismatch;
    redir_thread_d = mismatch ? i_resolve_thread : 2'd0;
    redir_target_d = mismatch ? i_resolve_target : '0;
    error_d        = i_resolve_valid && q_empty[i_resolve_thread];
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stage_push_q   <= 1'b0;
      stage_pop_q    <= 1'b0;
      stage_addr_q   <= '0;
      stage_thread_q <= 2'd0;
      redirect_q     <= 1'b0;
      redir_thread_q <= 2'd0;
      redir_target_q <= '0;
      error_q        <= 1'b0;
    end else begin
      stage_push_q   <= stage_push_d;
      stage_pop_q    <= stage_pop_d;
      stage_addr_q   <= stage_addr_d;
      stage_thread_q <= stage_thread_d;
      redirect_q     <= redirect_d;
      redir_thread_q <= redir_thread_d;
      redir_target_q <= redir_target_d;
      error_q        <= error_d;
    end
  end

  assign o_push            = stage_push_q;
  assign o_pop             = stage_pop_q;
  assign o_address         = stage_addr_q;
  assign o_thread          = stage_thread_q;
  assign o_pred_valid      = stage_pop_q;
  assign o_pred_target     = stage_pop_q ? i_stack_address : '0;
  assign o_redirect        = redirect_q;
  assign o_redirect_thread = redir_thread_q;
  assign o_redirect_target = redir_target_q;
  assign o_error           = error_q;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Directed bench for return_stack_ctrl: decode, prediction checking, flush, full and reset cases.
module tb_return_stack_ctrl;

  localparam int AW = 22;

  localparam logic [31:0] I_JAL   = 32'h0C00_0000;
  localparam logic [31:0] I_JR31  = 32'h03E0_0008;
  localparam logic [31:0] I_JR5   = 32'h00A0_0008;
  localparam logic [31:0] I_NOP   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [31:0]   instr = '0;
  logic [AW-1:0] pc = '0;
  logic [1:0]    thr = '0;
  logic          push, pop, pred_valid;
  logic [AW-1:0] address, pred_target;
  logic [1:0]    othr;
  logic [AW-1:0] stack_addr = '0;
  logic          res_valid = 1'b0;
  logic [1:0]    res_thr = '0;
  logic [AW-1:0] res_target = '0;
  logic          redirect, error;
  logic [1:0]    redir_thr;
  logic [AW-1:0] redir_target;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  return_stack_ctrl #(.ADDRESS_WIDTH(AW), .CHECK_DEPTH(4)) dut (
    .i_Clk            (clk),
    .i_Reset_n        (rst_n),
    .i_valid          (valid),
    .o_ready          (ready),
    .i_instr          (instr),
    .i_pc             (pc),
    .i_thread         (thr),
    .o_push           (push),
    .o_pop            (pop),
    .o_address        (address),
    .o_thread         (othr),
    .i_stack_address  (stack_addr),
    .o_pred_valid     (pred_valid),
    .o_pred_target    (pred_target),
    .i_resolve_valid  (res_valid),
    .i_resolve_thread (res_thr),
    .i_resolve_target (res_target),
    .o_redirect       (redirect),
    .o_redirect_thread(redir_thr),
    .o_redirect_target(redir_target),
    .o_error          (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [AW-1:0] p,
                       input logic [1:0] t);
    valid = v;
    instr = ins;
    pc    = p;
    thr   = t;
    #1;
  endtask

  task automatic resolve(input logic v, input logic [1:0] t, input logic [AW-1:0] tgt);
    res_valid  = v;
    res_thr    = t;
    res_target = tgt;
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_pred", 32'(pred_valid), 32'd0);
    chk("rst_redir", 32'(redirect), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    rst_n = 1'b1;
    tick();

    // jal at 0x100, thread 0
    drive(1'b1, I_JAL, 22'h000100, 2'd0);
    chk("jal_ready", 32'(ready), 32'd1);
    tick();
    drive(1'b0, I_NOP, '0, 2'd0);
    chk("jal_push", 32'(push), 32'd1);
    chk("jal_addr", 32'(address), 32'h102);
    chk("jal_thr", 32'(othr), 32'd0);
    chk("jal_pop", 32'(pop), 32'd0);
    tick();
    chk("jal_push_once", 32'(push), 32'd0);

    // jr $31 thread 1, correct prediction
    stack_addr = 22'h0000A4;
    drive(1'b1, I_JR31, 22'h000200, 2'd1);
    tick();
    drive(1'b0, I_NOP, '0, 2'd0);
    chk("jr_pop", 32'(pop), 32'd1);
    chk("jr_pvalid", 32'(pred_valid), 32'd1);
    chk("jr_ptarget", 32'(pred_target), 32'h0A4);
    chk("jr_thr", 32'(othr), 32'd1);
    tick();
    resolve(1'b1, 2'd1, 22'h0000A4);
    tick();
    resolve(1'b0, 2'd0, '0);
    chk("match_noredir", 32'(redirect), 32'd0);
    chk("match_noerr", 32'(error), 32'd0);
    resolve(1'b1, 2'd1, 22'h0000A4);
    tick();
    resolve(1'b0, 2'd0, '0);
    chk("match_drained_err", 32'(error), 32'd1);
    tick();
    chk("err_one_cycle", 32'(error), 32'd0);

    // jr $31 thread 1, mispredict, with a same-cycle thread-1 decode that must drop
    drive(1'b1, I_JR31, 22'h000210, 2'd1);
    tick();
    drive(1'b0, I_NOP, '0, 2'd0);
    tick();
    resolve(1'b1, 2'd1, 22'h0000B0);
    drive(1'b1, I_JAL, 22'h000300, 2'd1);
    tick();
    resolve(1'b0, 2'd0, '0);
    drive(1'b0, I_NOP, '0, 2'd1);
    chk("mis_redir", 32'(redirect), 32'd1);
    chk("mis_rthr", 32'(redir_thr), 32'd1);
    chk("mis_rtgt", 32'(redir_target), 32'h0B0);
    chk("mis_dropped", 32'(push), 32'd0);
    chk("flush_ready_t1", 32'(ready), 32'd0);
    drive(1'b0, I_NOP, '0, 2'd2);
    chk("flush_ready_t2", 32'(ready), 32'd1);
    tick();
    chk("redir_once", 32'(redirect), 32'd0);
    drive(1'b0, I_NOP, '0, 2'd1);
    chk("run_ready_t1", 32'(ready), 32'd1);
    resolve(1'b1, 2'd1, 22'h0000B0);
    tick();
    resolve(1'b0, 2'd0, '0);
    chk("flushed_empty_err", 32'(error), 32'd1);

    // Fill thread 2 with four pops
    stack_addr = 22'h000055;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, I_JR31, 22'h000400, 2'd2);
      chk($sformatf("fill_ready_%0d", i), 32'(ready), 32'd1);
      tick();
    end
    drive(1'b1, I_JR31, 22'h000400, 2'd2);
    chk("full_jr_t2", 32'(ready), 32'd0);
    drive(1'b1, I_JR31, 22'h000400, 2'd3);
    chk("full_jr_t3", 32'(ready), 32'd1);
    drive(1'b1, I_JAL, 22'h000400, 2'd2);
    chk("full_jal_t2", 32'(ready), 32'd1);
    drive(1'b0, I_JR31, 22'h000400, 2'd2);
    tick();
    chk("full_jr_t2_b", 32'(ready), 32'd0);
    resolve(1'b1, 2'd2, 22'h000055);
    chk("deq_no_bypass", 32'(ready), 32'd0);
    tick();
    resolve(1'b0, 2'd0, '0);
    chk("deq_noredir", 32'(redirect), 32'd0);
    chk("deq_ready_t2", 32'(ready), 32'd1);

    // Address wrap and a non-ra jr
    drive(1'b1, I_JAL, 22'h3FFFFF, 2'd3);
    tick();
    drive(1'b1, I_JR5, 22'h000010, 2'd3);
    chk("wrap_push", 32'(push), 32'd1);
    chk("wrap_addr", 32'(address), 32'h000001);
    chk("wrap_thr", 32'(othr), 32'd3);
    tick();
    drive(1'b0, I_NOP, '0, 2'd0);
    chk("jr5_pop", 32'(pop), 32'd0);
    chk("jr5_push", 32'(push), 32'd0);
    chk("jr5_pred", 32'(pred_valid), 32'd0);

    // Resolve on an empty thread-3 queue
    resolve(1'b1, 2'd3, 22'h000123);
    tick();
    resolve(1'b0, 2'd0, '0);
    chk("empty_err_t3", 32'(error), 32'd1);
    chk("empty_noredir", 32'(redirect), 32'd0);

    // Two thread-0 entries outstanding, then reset mid-stream with a push in the stage
    stack_addr = 22'h000077;
    drive(1'b1, I_JR31, 22'h000500, 2'd0);
    tick();
    tick();
    drive(1'b1, I_JAL, 22'h000600, 2'd0);
    tick();
    drive(1'b0, I_NOP, '0, 2'd0);
    chk("pre_rst_push", 32'(push), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_push", 32'(push), 32'd0);
    chk("mid_rst_addr", 32'(address), 32'd0);
    chk("mid_rst_pred", 32'(pred_valid), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    resolve(1'b1, 2'd0, 22'h000077);
    tick();
    resolve(1'b0, 2'd0, '0);
    chk("post_rst_err", 32'(error), 32'd1);
    chk("post_rst_noredir", 32'(redirect), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_stack_ctrl.md
# return_stack_ctrl

Front-end controller that drives the per-thread jump (return-address) stack. It decodes fetched instruction words for four hardware threads, issues push commands for `jal`/`jalr` and pop commands for `jr $31`, and forwards the popped address as a return-target prediction. It tracks every outstanding prediction in a per-thread check queue, compares each against the execute stage's resolved target, and issues a redirect on mismatch. It sits between fetch/pre-align and the jump stack.

## Interface
- ADDRESS_WIDTH, 22, word-address width of PCs and stack entries.
- CHECK_DEPTH, 4, outstanding unresolved predictions per thread (power of two).
- i_Clk  in  1  clock.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  instruction word present.
- o_ready  out  1  decode accepts i_valid this cycle (combinational, per i_thread).
- i_instr  in  32  instruction word.
- i_pc  in  ADDRESS_WIDTH  word address of i_instr.
- i_thread  in  2  thread of i_instr.
- o_push  out  1  one-cycle push command to stack.
- o_pop  out  1  one-cycle pop command to stack.
- o_address  out  ADDRESS_WIDTH  return address to push.
- o_thread  out  2  thread of current command.
- i_stack_address  in  ADDRESS_WIDTH  stack top for o_thread (combinational from stack).
- o_pred_valid  out  1  prediction valid.
- o_pred_target  out  ADDRESS_WIDTH  predicted return target.
- i_resolve_valid  in  1  execute resolved a `jr $31`.
- i_resolve_thread  in  2  its thread.
- i_resolve_target  in  ADDRESS_WIDTH  actual target.
- o_redirect  out  1  one-cycle mispredict redirect.
- o_redirect_thread  out  2  thread to redirect.
- o_redirect_target  out  ADDRESS_WIDTH  correct target.
- o_error  out  1  one-cycle pulse: resolve with empty check queue.

## Operation
- Decode: `jal` = opcode 6'b000011; `jalr` = opcode 0, funct 6'b001001 → push. `jr` = opcode 0, funct 6'b001000, rs = 31 → pop. Other instructions, including `jr` with rs ≠ 31, produce no command.
- Push address = i_pc + 2 (delay slot), modulo 2^ADDRESS_WIDTH.
- Accept = i_valid & o_ready. An accepted instruction loads a one-entry command stage register.
- o_ready for thread t = state[t] == RUN and count[t] + pending_pop_for_t < CHECK_DEPTH. The full check applies only when the instruction decodes to a pop. Pushes and non-commands need only RUN.
- Stage pop cycle: o_pred_target = i_stack_address. The entry is written into check queue[o_thread] at the cycle's end.
- Resolve: compare i_resolve_target with the head of queue[i_resolve_thread], then dequeue.
  - Match → no further action.
  - Mismatch → o_redirect with i_resolve_target, flush that thread's queue, and enter FLUSH.
- Resolve on an empty queue → o_error; no other effect.
- Per-thread state machine: RUN → FLUSH on mismatch. FLUSH → RUN after exactly one cycle. In FLUSH, o_ready is low for that thread.
- Stack contents are not repaired on mispredict. Stack-pointer recovery is out of scope.

## Timing
- Reset: all outputs 0. Counts 0, queues empty, all threads RUN, stage empty.
- Accept at cycle N → o_push/o_pop, o_address, o_thread, o_pred_valid at N+1, for exactly one cycle.
- Resolve at M → o_redirect (and o_error) at M+1.
- A resolve must arrive at least one cycle after the matching o_pred_valid. No bypass.
- Simultaneous enqueue and dequeue on the same thread: both take effect and the count is unchanged. The full check uses the registered count; a same-cycle dequeue does not free a slot.
- Mismatch at M on thread t:
  - The flush overrides a same-edge enqueue from the stage for t.
  - A decode accepted for t at M is dropped; the stage is not loaded.
- Resolves for different threads are independent. Only one resolve per cycle.
- Reset asserted mid-operation clears everything immediately. In-flight commands are lost.

## Structure
- Package `return_stack_pkg`:
  - opcode/funct constants (OP_JAL, OP_SPECIAL, FN_JR, FN_JALR), RA_REG = 31;
  - NUM_THREADS = 4;
  - thread-state enum {RUN, FLUSH}.
- Sub-module `ret_check_fifo`: one per thread, depth CHECK_DEPTH, with push/pop/flush/count/head. Instantiated four times.

## Test plan
- `jal` at pc 0x000100, thread 0 → next cycle o_push=1, o_address=0x000102, o_thread=0, o_pop=0.
- `jr $31` on thread 1 with i_stack_address=0x0000A4 → o_pop=1, o_pred_valid=1, o_pred_target=0x0000A4. Later resolve thread 1 target 0x0000A4 → no redirect; count[1] returns to 0.
- Same pop, resolved target 0x0000B0 → next cycle o_redirect=1, thread 1, target 0x0000B0. Thread-1 queue empty; o_ready low for thread 1 for one cycle, high for thread 2.
- Four `jr $31` on thread 2 → o_ready=0 for a fifth thread-2 `jr` and =1 for thread 3 or a thread-2 `jal`. One thread-2 resolve → o_ready=1 the following cycle.
- `jal` at pc 0x3FFFFF → o_address=0x000001. `jr $5` → no command, no prediction.
- Resolve on thread 3 with an empty queue → o_error pulse. Assert reset mid-stream with two thread-0 entries outstanding → all outputs 0, subsequent thread-0 resolve → o_error.
